// File: rtl/alu_exec_ctrl.sv
// Three-state execute controller for an external combinational Alu.
// It holds an 8 x 16 register file and a carry flag, and retires one instruction every three cycles.
module alu_exec_ctrl (
  input  logic        clk,
  input  logic        resetN,
  input  logic [15:0] instr,
  input  logic        instrValid,
  output logic        instrReady,
  output logic        done,
  output logic        doneError,
  output logic [15:0] operand1,
  output logic [15:0] operand2,
  output logic        carryIn,
  output logic        enableAlu,
  output logic        enableShift,
  output logic        enableLoad,
  output logic [2:0]  aluOperation,
  output logic [2:0]  shiftOperation,
  output logic [2:0]  loadOperation,
  input  logic [15:0] result,
  input  logic        carryOut,
  input  logic [2:0]  dbgAddr,
  output logic [15:0] dbgData,
  output logic        carryFlag
);

  typedef enum logic [1:0] {StIdle, StExec, StRetire} state_e;

  localparam logic [1:0] ClsAlu   = 2'b00;
  localparam logic [1:0] ClsShift = 2'b01;
  localparam logic [1:0] ClsLoad  = 2'b10;
  localparam logic [1:0] ClsLdi   = 2'b11;

  state_e      state_q, state_d;
  logic [15:0] instr_q;
  logic [15:0] regs_q [8];
  logic        carry_q;

  logic [1:0]  cls;
  logic [2:0]  op, rd, rs, rt;
  logic [7:0]  imm;
  logic        is_ldi, illegal, accept;

  assign cls     = instr_q[15:14];
  assign op      = instr_q[13:11];
  assign rd      = instr_q[10:8];
  assign rs      = instr_q[7:5];
  assign rt      = instr_q[4:2];
  assign imm     = instr_q[7:0];
  assign is_ldi  = (cls == ClsLdi);
  assign illegal = is_ldi && (op != 3'b000);
  assign accept  = instrValid && instrReady;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StExec;
      StExec:   state_d = StRetire;
      StRetire: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= StIdle;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) instr_q <= instr;
    end
  end

  // Writeback on the EXEC->RETIRE edge; Alu result is built from pre-write register values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
      carry_q <= 1'b0;
    end else if (state_q == StExec) begin
      if (!is_ldi) begin
        regs_q[rd] <= result;
        carry_q    <= carryOut;
      end else if (!illegal) begin
        regs_q[rd] <= {8'h00, imm};
      end
    end
  end

  always_comb begin
    instrReady     = (state_q == StIdle);
    done           = (state_q == StRetire);
    doneError      = (state_q == StRetire) && illegal;
    carryIn        = carry_q;
    carryFlag      = carry_q;
    dbgData        = regs_q[dbgAddr];
    operand1       = '0;
    operand2       = '0;
    enableAlu      = 1'b0;
    enableShift    = 1'b0;
    enableLoad     = 1'b0;
    aluOperation   = '0;
    shiftOperation = '0;
    loadOperation  = '0;
    if ((state_q == StExec) && !is_ldi) begin
      operand1 = regs_q[rs];
      operand2 = regs_q[rt];
      case (cls)
        ClsAlu: begin
          enableAlu    = 1'b1;
          aluOperation = op;
        end
        ClsShift: begin
          enableShift    = 1'b1;
          shiftOperation = op;
        end
        ClsLoad: begin
          enableLoad    = 1'b1;
          loadOperation = op;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_exec_ctrl.md
ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

Interface
REQ-001 Parameter: none; data width SHALL be fixed at 16 bits, register file fixed at 8 x 16.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-003 resetN  input  1  reset; asynchronous, active-low.
REQ-004 instr  input  16  instruction word, sampled on the accept edge.
REQ-005 instrValid  input  1  instruction offered.
REQ-006 instrReady  output  1  controller can accept; accept = instrValid && instrReady at rising edge.
REQ-007 done  output  1  one-cycle pulse, instruction retired.
REQ-008 doneError  output  1  qualifies done: instruction was illegal.
REQ-009 operand1, operand2  output  16 each  drive the Alu operand ports.
REQ-010 carryIn  output  1  drives the Alu carry input from the internal carry flag.
REQ-011 enableAlu, enableShift, enableLoad  output  1 each  Alu class enables.
REQ-012 aluOperation, shiftOperation, loadOperation  output  3 each  Alu opcodes, encodings from alu.v (ADD_OP, ADC_OP, NOT_OP, SHL_OP, SHR_OP, ASHR_OP, ROL_OP, ROR_OP, COPY_OP, SWAP_OP, LDL_OP, LDH_OP) passed unchanged.
REQ-013 result  input  16, carryOut  input  1  from the Alu, combinational.
REQ-014 dbgAddr  input  3, dbgData  output  16  combinational register-file read port.
REQ-015 carryFlag  output  1  current carry flag.

Function
REQ-016 Instruction format: [15:14] class, [13:11] op, [10:8] rd, [7:5] rs, [4:2] rt, [1:0] ignored; class 00 = alu, 01 = shift, 10 = load, 11 = LDI.
REQ-017 LDI: rd, imm = instr[7:0]; legal only when op = 000; writes R[rd] <= {8'h00, imm}; carry flag unchanged; Alu not used.
REQ-018 FSM states IDLE, EXEC, RETIRE; IDLE -> EXEC on accept; EXEC -> RETIRE unconditionally; RETIRE -> IDLE unconditionally.
REQ-019 instrReady SHALL be 1 only in IDLE; throughput is one instruction per 3 cycles.
REQ-020 Instruction SHALL be latched on accept; instr changes afterwards have no effect.
REQ-021 In EXEC: operand1 = R[rs], operand2 = R[rt], carryIn = carry flag, exactly one enable high per class, opcode on the matching operation port; all other enables and opcodes 0.
REQ-022 Outside EXEC, and for LDI or illegal instructions, all enables, opcodes, and operands SHALL be 0; carryIn SHALL still follow the carry flag.
REQ-023 On the EXEC->RETIRE edge, legal alu/shift/load instructions: R[rd] <= result, carry flag <= carryOut; LDI writes per REQ-017.
REQ-024 Illegal instruction (class 11, op != 000): no register or carry update.
REQ-025 done = 1 for exactly the RETIRE cycle; doneError = 1 in the same cycle iff illegal, else 0.
REQ-026 rd = rs or rd = rt is legal; the write uses the result computed from pre-write values.
REQ-027 dbgData = R[dbgAddr] at all times, reflecting the write in the cycle after the write edge.

Reset
REQ-028 resetN low SHALL immediately force: state IDLE, R0..R7 = 0, carry flag = 0, done = doneError = 0, all Alu control/operand outputs = 0; instrReady = 1 while in IDLE.
REQ-029 Reset asserted in EXEC or RETIRE SHALL abort the instruction with no writeback and no done pulse.

Verification
REQ-030 Reset release -> instrReady = 1, done = 0, carryFlag = 0, dbgData = 0 for all dbgAddr.
REQ-031 LDI R1,0x0A; LDI R2,0x0F; ADC rd=R3, rs=R1, rt=R2 with carry 0 -> R3 = 0x0019, carryFlag = 0; in the EXEC cycle enableAlu = 1 and aluOperation = ADC_OP.
REQ-032 LDI R4,0x82; SWAP R4->R4 -> 0x8200; SHL R4->R5 -> R5 = 0x0400, carryFlag = 1; then ROL R4->R6 -> R6 = 0x0401, carryFlag = 1.
REQ-033 instr = 0xC800 (class 11, op 001) -> done = 1 and doneError = 1 in the RETIRE cycle; registers and carry unchanged.
REQ-034 instrValid held high for 9 cycles with changing instr -> exactly 3 accepts, instrReady low in EXEC/RETIRE, done pulses 2 cycles after each accept.
REQ-035 resetN pulsed low during EXEC of ADD R1,R1,R2 -> R1 = 0, no done pulse, FSM in IDLE; the next instruction executes normally.
